// File: rtl/core_seq_ctrl.sv
// Layer sequencer for the systolic core: per kij loads weights, activations, executes, drains OFIFO.
// Define CORE_SEQ_ACC_EN to add the ACC state that sums the 9 kij partials of each 4x4 output.
module core_seq_ctrl #(
  parameter int unsigned COL     = 8,
  parameter int unsigned ROW     = 8,
  parameter int unsigned LEN_NIJ = 36,
  parameter int unsigned LEN_KIJ = 9,
  parameter logic [10:0] W_BASE  = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_sel,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        core_clr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_cnt
);

  localparam int unsigned ExecLen = LEN_NIJ + ROW + COL;
  localparam int unsigned AccLast = LEN_KIJ + 2;
  localparam int unsigned Max1    = (COL > LEN_NIJ) ? COL : LEN_NIJ;
  localparam int unsigned Max2    = (ExecLen > Max1) ? ExecLen : Max1;
  localparam int unsigned CntMax  = (AccLast + 1 > Max2) ? AccLast + 1 : Max2;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned TW      = $clog2(LEN_NIJ + 1);
  localparam logic [34:0] IdleWord = 35'h1800C0000;

  typedef enum logic [3:0] {
    StIdle, StWL0, StG1, StWLd, StG2, StXL0, StG3, StExec, StG4, StDrain, StFin
`ifdef CORE_SEQ_ACC_EN
    , StAcc
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      kij_q, kij_d;
  logic [TW-1:0]   t_q, t_d;
  logic            mode_q, mode_d;
  logic [34:0]     inst_q, inst_d;
  logic            busy_q, done_q;
  logic            drain_wr;
  logic [10:0]     drain_addr;

`ifdef CORE_SEQ_ACC_EN
  logic [3:0]      o_q, o_d;
  logic            clr_q, clr_d;
  logic [CntW-1:0] acc_k;
  logic [10:0]     acc_addr;
`endif

  assign drain_addr = 11'(kij_q) * 11'(LEN_NIJ) + 11'(t_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kij_d    = kij_q;
    t_d      = t_q;
    mode_d   = mode_q;
    drain_wr = 1'b0;
`ifdef CORE_SEQ_ACC_EN
    o_d      = o_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWL0;
          cnt_d   = '0;
          kij_d   = '0;
          t_d     = '0;
          mode_d  = mode_sel;
        end
      end
      StWL0: begin
        if (cnt_q == CntW'(COL - 1)) begin
          state_d = StG1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CntW'(1);
      end
      StG1: state_d = StWLd;
      StWLd: begin
        if (cnt_q == CntW'(COL - 1)) begin
          state_d = StG2;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CntW'(1);
      end
      StG2: state_d = StXL0;
      StXL0: begin
        if (cnt_q == CntW'(LEN_NIJ - 1)) begin
          state_d = StG3;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CntW'(1);
      end
      StG3: state_d = StExec;
      StExec: begin
        if (cnt_q == CntW'(ExecLen - 1)) begin
          state_d = StG4;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CntW'(1);
      end
      StG4: begin
        state_d = StDrain;
        t_d     = '0;
      end
      StDrain: begin
        // t counts rows already written; a write issues the cycle after ofifo_valid is seen
        if (t_q == TW'(LEN_NIJ)) begin
          t_d   = '0;
          cnt_d = '0;
          if (kij_q == 4'(LEN_KIJ - 1)) begin
`ifdef CORE_SEQ_ACC_EN
            state_d = StAcc;
            o_d     = '0;
`else
            state_d = StFin;
`endif
          end else begin
            state_d = StWL0;
            kij_d   = kij_q + 4'd1;
          end
        end else if (ofifo_valid) begin
          drain_wr = 1'b1;
          t_d      = t_q + TW'(1);
        end
      end
`ifdef CORE_SEQ_ACC_EN
      StAcc: begin
        if (cnt_q == CntW'(AccLast)) begin
          cnt_d = '0;
          if (o_q == 4'd15) state_d = StFin;
          else o_d = o_q + 4'd1;
        end else cnt_d = cnt_q + CntW'(1);
      end
`endif
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef CORE_SEQ_ACC_EN
  // Slot 0 clears, slots 1..LEN_KIJ read kij partials, acc trails reads by one, last slot idles
  assign acc_k    = cnt_d - CntW'(1);
  assign acc_addr = 11'(acc_k) * 11'(LEN_NIJ)
                  + (11'(o_d[3:2]) + 11'(acc_k / CntW'(3))) * 11'd6
                  + 11'(o_d[1:0]) + 11'(acc_k % CntW'(3));
  assign clr_d    = (state_d == StAcc) && (cnt_d == '0);
`endif

  always_comb begin
    inst_d     = IdleWord;
    inst_d[34] = (state_d != StIdle) ? mode_d : 1'b0;
    case (state_d)
      StWL0: begin
        inst_d[19]   = 1'b0;
        inst_d[2]    = 1'b1;
        inst_d[17:7] = W_BASE + 11'(kij_d) * 11'(COL) + 11'(cnt_d);
      end
      StWLd: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
      end
      StXL0: begin
        inst_d[19]   = 1'b0;
        inst_d[2]    = 1'b1;
        inst_d[17:7] = 11'(cnt_d);
      end
      StExec: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      StDrain: begin
        if (drain_wr) begin
          inst_d[6]     = 1'b1;
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = drain_addr;
        end
      end
`ifdef CORE_SEQ_ACC_EN
      StAcc: begin
        if ((cnt_d != '0) && (cnt_d <= CntW'(LEN_KIJ))) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = acc_addr;
        end
        if ((cnt_d >= CntW'(2)) && (cnt_d <= CntW'(LEN_KIJ + 1))) inst_d[33] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      kij_q   <= '0;
      t_q     <= '0;
      mode_q  <= 1'b0;
      inst_q  <= IdleWord;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CORE_SEQ_ACC_EN
      o_q     <= '0;
      clr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFin);
`ifdef CORE_SEQ_ACC_EN
      o_q     <= o_d;
      clr_q   <= clr_d;
`endif
    end
  end

  assign inst    = inst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign kij_cnt = kij_q;
`ifdef CORE_SEQ_ACC_EN
  assign core_clr = clr_q;
`else
  assign core_clr = 1'b0;
`endif

endmodule

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL have parameter COL, default 8, meaning array columns and weight rows per kij.
REQ-002 SHALL have parameter ROW, default 8, meaning array rows.
REQ-003 SHALL have parameter LEN_NIJ, default 36, meaning activation vectors per tile (6x6).
REQ-004 SHALL have parameter LEN_KIJ, default 9, meaning kernel positions (3x3).
REQ-005 SHALL have parameter W_BASE, default 11'h400, meaning xmem base of the weights for kij 0; kij k sits at W_BASE+k*COL.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, meaning reset, asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, meaning a one-cycle pulse that begins a layer; ignored while busy.
REQ-009 SHALL have port mode_sel, input, 1, meaning dataflow mode, 0=WS and 1=OS, sampled at start.
REQ-010 SHALL have port ofifo_valid, input, 1, meaning the core OFIFO has a row ready.
REQ-011 SHALL have port inst, output, 35, meaning the core instruction, registered.
- Bit map: 34 mode, 33 acc, 32 CEN_pmem, 31 WEN_pmem, 30:20 A_pmem, 19 CEN_xmem, 18 WEN_xmem, 17:7 A_xmem, 6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load.
REQ-012 SHALL have port core_clr, output, 1, meaning a one-cycle clear pulse to the core SFP/accumulator.
REQ-013 SHALL have port busy, output, 1, meaning the sequencer is not IDLE.
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse when the layer completes.
REQ-015 SHALL have port kij_cnt, output, 4, meaning the current kernel position.

Function
REQ-016 SHALL hold inst at the idle word whenever no phase drives a field.
- Idle word: bits 32, 31, 19 and 18 = 1; all other bits = 0.
- Bit 34 = latched mode_sel while busy, 0 in IDLE.
REQ-017 SHALL sequence the states IDLE -> W_L0 -> G1 -> W_LD -> G2 -> X_L0 -> G3 -> EXEC -> G4 -> DRAIN, each G state lasting 1 cycle.
- From DRAIN, go to W_L0 with kij+1 if kij<LEN_KIJ-1.
- Otherwise go to ACC (macro on) or FIN (macro off).
REQ-018 W_L0 SHALL last COL cycles.
- CEN_xmem=0, WEN_xmem=1, l0_wr=1.
- A_xmem = W_BASE+kij*COL+i.
REQ-019 W_LD SHALL last COL cycles with l0_rd=1 and load=1.
REQ-020 X_L0 SHALL last LEN_NIJ cycles.
- CEN_xmem=0, l0_wr=1.
- A_xmem = i, for i = 0..LEN_NIJ-1.
REQ-021 EXEC SHALL last LEN_NIJ+ROW+COL cycles with l0_rd=1 and execute=1.
REQ-022 DRAIN SHALL write LEN_NIJ rows.
- On each cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*LEN_NIJ+t, then t increments.
- On cycles with ofifo_valid=0: hold t and emit the idle pmem/ofifo fields (stall).
REQ-023 FIN SHALL pulse done for 1 cycle, then return to IDLE.
REQ-024 A start pulse while busy SHALL be ignored, with no state change.
REQ-025 All counters SHALL be sized for their maximum value without wrap.
- A_pmem maximum = LEN_KIJ*LEN_NIJ-1 = 323, which fits in 11 bits.

Reset
REQ-026 Asserting reset low at any time, including mid-phase, SHALL asynchronously force the following; release is synchronous to the next clk edge.
- State = IDLE; kij_cnt=0; all counters = 0.
- inst = idle word; core_clr=0, busy=0, done=0.
REQ-027 After reset the block SHALL wait for a fresh start; no partial layer resumes.

Configuration
REQ-028 Macro CORE_SEQ_ACC_EN defined SHALL compile in state ACC, which runs per output o = 0..15 (orow=o/4, ocol=o%4).
- Pulse core_clr for 1 cycle.
- Issue LEN_KIJ pmem reads: CEN_pmem=0, WEN_pmem=1, A_pmem = k*LEN_NIJ + (orow+k/3)*6 + (ocol+k%3).
- Drive acc=1 for LEN_KIJ cycles, starting one cycle after the first read.
- Insert 1 idle cycle, then move to the next output; go to FIN after o=15.
REQ-029 Without CORE_SEQ_ACC_EN, the ACC state and address logic SHALL be absent, DRAIN of the last kij SHALL go to FIN, and core_clr SHALL be tied to 0.

Verification
REQ-030 Reset released, start with mode_sel=0 -> next cycle busy=1, inst[19]=0, inst[2]=1, A_xmem=0x400; W_L0 runs exactly 8 cycles.
REQ-031 kij=3 W_L0 -> A_xmem sequence 0x418..0x41F; EXEC lasts exactly 52 cycles with inst[1]=1 and inst[3]=1.
REQ-032 ofifo_valid held 0 for 5 cycles mid-DRAIN of kij=2 -> A_pmem frozen with CEN_pmem=1; after release it resumes at 72+t with no address skipped; the last write is 107.
REQ-033 With CORE_SEQ_ACC_EN, output o=5 -> A_pmem reads 7, 44, 81, 121, 158, 195, 235, 272, 309; acc=1 for 9 cycles lagging by one; done pulses once after o=15.
REQ-034 reset low during EXEC of kij=4 -> same cycle inst = idle word, busy=0, kij_cnt=0; a subsequent start restarts at kij 0.
REQ-035 start pulsed while busy -> no state change; mode_sel=1 at start -> inst[34]=1 for the entire layer.
